// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store to a word-aligned req/ready bus with lane steering and load extension.
// Optional LSU_TIMEOUT_EN aborts a bus wait after TIMEOUT_CYCLES cycles with err.
module load_store_unit #(
  parameter int Width          = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic [2:0]       funct3_i,
  input  logic [Width-1:0] addr_i,
  input  logic [Width-1:0] wdata_i,
  output logic             stall_o,
  output logic [Width-1:0] rdata_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [Width-1:0] mem_addr_o,
  output logic [3:0]       mem_be_o,
  output logic [Width-1:0] mem_wdata_o,
  input  logic             mem_ready_i,
  input  logic [Width-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
  state_t state_q, state_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d, done_q, done_d, err_q, err_d;
  logic [Width-1:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [3:0] mem_be_q, mem_be_d;
  logic [2:0] f3_q, f3_d;
  logic [1:0] off_q, off_d;
  logic req, bad_f3, misal, err_req;
  logic [3:0] be;
  logic [Width-1:0] wd, sh, ext;
`ifdef LSU_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
`endif
  assign req     = mem_read_i | mem_write_i;
  // stores accept only B/H/W; loads also accept BU/HU
  assign bad_f3  = mem_write_i ? (funct3_i[2] | (&funct3_i[1:0])) : ((&funct3_i[1:0]) | (funct3_i[2] & funct3_i[1]));
  assign misal   = (funct3_i[1:0] == 2'd1 && addr_i[0]) || (funct3_i[1:0] == 2'd2 && addr_i[1:0] != 2'b00);
  assign err_req = (mem_read_i & mem_write_i) | bad_f3 | misal;
  assign be      = funct3_i[1:0] == 2'd0 ? 4'b0001 << addr_i[1:0] :
                   funct3_i[1:0] == 2'd1 ? 4'b0011 << addr_i[1:0] : 4'b1111;
  assign wd      = funct3_i[1:0] == 2'd0 ? {4{wdata_i[7:0]}} :
                   funct3_i[1:0] == 2'd1 ? {2{wdata_i[15:0]}} : wdata_i;
  assign sh      = mem_rdata_i >> {off_q, 3'b000};
  assign ext     = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                   f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
  assign stall_o = (state_q == IDLE && req) || state_q == BUS;
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    f3_d        = f3_q;
    off_d       = off_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: if (req) begin
        if (err_req) begin
          state_d = DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          state_d     = BUS;
          mem_req_d   = 1'b1;
          mem_we_d    = mem_write_i;
          mem_addr_d  = {addr_i[Width-1:2], 2'b00};
          mem_be_d    = be;
          mem_wdata_d = wd;
          f3_d        = funct3_i;
          off_d       = addr_i[1:0];
`ifdef LSU_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      BUS: begin
        if (mem_ready_i) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          rdata_d   = mem_we_q ? '0 : ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
          rdata_d   = '0;
        end else cnt_d = cnt_q + 8'd1;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      f3_q        <= '0;
      off_q       <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      done_q      <= done_d;
      err_q       <= err_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_be_o    = mem_be_q;
  assign mem_wdata_o = mem_wdata_q;
  assign rdata_o     = rdata_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized and directed checks of load_store_unit against a transaction-level model.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_read = 1'b0, mem_write = 1'b0, mem_ready = 1'b0;
  logic [2:0] funct3 = '0;
  logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
  logic stall, done, err, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  int n_tests = 0, n_fail = 0;
  logic [31:0] got;
  load_store_unit dut (
    .clk(clk), .rst_n(rst_n), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata), .stall_o(stall),
    .rdata_o(rdata), .done_o(done), .err_o(err), .mem_req_o(mem_req),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
    .mem_wdata_o(mem_wdata), .mem_ready_i(mem_ready), .mem_rdata_i(mem_rdata)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic bit ref_legal(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    bit f3_ok = wr ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    return !(rd && wr) && f3_ok && (a % nb == 0);
  endfunction
  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int nb = 1 << f3[1:0];
    int off = int'(a % 4);
    logic [3:0] b = '0;
    for (int i = 0; i < 4; i++) b[i] = (i >= off && i < off + nb);
    return b;
  endfunction
  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int nb = 1 << f3[1:0];
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
    return r;
  endfunction
  function automatic logic [31:0] ref_rdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] md);
    int nb = 1 << f3[1:0];
    longint v = (longint'(md) >> (8 * (a % 4))) & ((64'sd1 << (8 * nb)) - 1);
    if (!f3[2] && v >= (64'sd1 << (8 * nb - 1))) v -= (64'sd1 << (8 * nb));
    return v[31:0];
  endfunction
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] md, input int dly, output logic [31:0] res);
    bit ok = ref_legal(rd, wr, f3, a);
    logic [3:0] eb = ref_be(f3, a);
    logic [31:0] ew = ref_wdata(f3, wd);
    logic [31:0] er = rd ? ref_rdata(f3, a, md) : 32'h0;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    mem_ready = 1'($urandom);
    #1 chk("stall_req", stall, 1);
    @(posedge clk); #1;
    if (!ok) begin
      chk("err_done", done, 1);
      chk("err_err", err, 1);
      chk("err_rdata", rdata, 0);
      chk("err_noreq", mem_req, 0);
      chk("err_stall", stall, 0);
    end else begin
      chk("bus_req", mem_req, 1);
      chk("bus_we", mem_we, wr);
      chk("bus_addr", mem_addr, {a[31:2], 2'b00});
      chk("bus_be", mem_be, eb);
      if (wr) chk("bus_wdata", mem_wdata, ew);
      chk("bus_stall", stall, 1);
      chk("bus_nodone", done, 0);
      mem_ready = 1'b0;
      for (int i = 0; i < dly; i++) begin
        addr = $urandom; funct3 = 3'($urandom); mem_rdata = $urandom;
        @(posedge clk); #1;
        chk("wait_req", mem_req, 1);
        chk("wait_addr", mem_addr, {a[31:2], 2'b00});
        chk("wait_be", mem_be, eb);
        if (wr) chk("wait_wdata", mem_wdata, ew);
        chk("wait_nodone", done, 0);
      end
      mem_ready = 1'b1; mem_rdata = md;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      chk("done", done, 1);
      chk("done_err", err, 0);
      chk("done_rdata", rdata, er);
      chk("done_req", mem_req, 0);
      chk("done_stall", stall, 0);
    end
    res = rdata;
    mem_read = 0; mem_write = 0;
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
  endtask
  initial begin
    #2;
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_rdata", rdata, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, got);
    chk("lw_val", got, 32'hDEADBEEF);
    access(1, 0, 3'b000, 32'h103, 0, 32'h80123456, 0, got);
    chk("lb_val", got, 32'hFFFFFF80);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80123456, 1, got);
    chk("lbu_val", got, 32'h00000080);
    access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 0, 4, got);
    access(1, 0, 3'b010, 32'h101, 0, 0, 0, got);
    access(1, 0, 3'b001, 32'h0FF, 0, 0, 0, got);
    access(1, 0, 3'b011, 32'h100, 0, 0, 0, got);
    access(1, 1, 3'b010, 32'h100, 0, 0, 0, got);
    for (int n = 0; n < 60; n++) begin
      int k = int'($urandom % 8);
      access(k < 4 || k == 7, k >= 4, 3'($urandom), $urandom, $urandom, $urandom, int'($urandom % 6), got);
    end
    // reset in the middle of a bus wait
    mem_read = 1; funct3 = 3'b010; addr = 32'h400; mem_ready = 0;
    @(posedge clk); #1;
    chk("pre_rst_req", mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", mem_req, 0);
    chk("arst_done", done, 0);
    chk("arst_err", err, 0);
    mem_read = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 3'b010, 32'h500, 0, 32'hCAFEF00D, 0, got);
    chk("post_rst_lw", got, 32'hCAFEF00D);
    mem_read = 1; funct3 = 3'b010; addr = 32'h300; mem_ready = 0;
    @(posedge clk); #1;
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      chk("to_wait_req", mem_req, 1);
    end
    @(posedge clk); #1;
    chk("to_req", mem_req, 0);
    chk("to_done", done, 1);
    chk("to_err", err, 1);
    chk("to_rdata", rdata, 0);
    mem_read = 0;
    @(posedge clk); #1;
`else
    repeat (100) @(posedge clk);
    #1 chk("hang_req", mem_req, 1);
    chk("hang_nodone", done, 0);
    mem_read = 0;
    #2 rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
`endif
    access(0, 1, 3'b000, 32'h601, 32'h000000A5, 0, 1, got);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
